vmx_col_accum: RTL and testbench
================================

// Module: vmx_col_accum
// PURPOSE
//  Drain stage below one vmx PE column. Consumes the 32-bit partial sums leaving the bottom PE
//  (sum_out), accumulates cfg_tiles partials per output element, then requantizes by right-shift
//  with unsigned saturation. Pushes each 16-bit result into an output FIFO drained via valid/ready.
//  Honours the same simd_mode split as the PE array: 0 = dual 8-bit lanes, 1 = single 16-bit lane.
// PARAMETERS
//  SUM_BITLEN   32  width of incoming partial sum (PE product width)
//  ACC_BITLEN   40  16-bit-mode accumulator width; 8-bit mode uses two 24-bit lane accumulators
//  OUT_BITLEN   16  result width (one 16-bit value or two packed 8-bit values)
//  FIFO_DEPTH   4   output FIFO entries, power of two, >=2
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           reset, asynchronous, active-low
//  start        in   1           one-cycle job start; sampled only in IDLE
//  cfg_simd     in   1           simd_mode for the job, latched on start
//  cfg_tiles    in   8           partials per output element; 0 treated as 1; latched on start
//  cfg_num_out  in   8           output elements in the job; 0 = empty job; latched on start
//  cfg_shift    in   5           requant right-shift amount, latched on start
//  sum_in       in   SUM_BITLEN  partial sum from bottom PE of column
//  sum_valid    in   1           sum_in valid
//  sum_ready    out  1           accept partial; transfer when sum_valid & sum_ready
//  out_data     out  OUT_BITLEN  FIFO head
//  out_valid    out  1           FIFO not empty
//  out_ready    in   1           consumer pop; pop when out_valid & out_ready
//  busy         out  1           state != IDLE
//  done         out  1           one-cycle pulse at job end
// BEHAVIOUR
//  Reset: state IDLE; sum_ready, out_valid, busy, done = 0; out_data = 0; accumulators, counters,
//   FIFO pointers/count = 0. Reset mid-job discards all FIFO contents and partial accumulation.
//  FSM: IDLE -start-> ACC (or DONE if cfg_num_out==0). ACC -last partial accepted-> PUSH.
//   PUSH -FIFO not full, more outputs-> ACC; -FIFO not full, last output-> DONE. DONE -> IDLE.
//  sum_ready = 1 only in ACC; start outside IDLE ignored; config registers unchanged mid-job.
//  ACC: on transfer, first partial of an element loads acc (acc = sum), later ones add; tile_cnt++.
//   Transfer with tile_cnt == tiles-1 moves to PUSH, tile_cnt cleared.
//  Arithmetic is unsigned. simd=1: acc40 += sum_in[31:0]. simd=0: lane0 acc24 += sum_in[15:0],
//   lane1 acc24 += sum_in[31:16], lanes independent with no cross-lane carry.
//  Requant (PUSH): r = acc >> cfg_shift, truncating. simd=1: out = (r > 16'hFFFF) ? 16'hFFFF : r[15:0].
//   simd=0: each lane saturates to 8'hFF and packs as {lane1, lane0}.
//  PUSH writes only when fifo_count < FIFO_DEPTH; otherwise it holds with value stable. A pop in
//   the same cycle does not free space for that cycle's push. Push and pop both allowed when not full.
//  Latency: last partial accepted in cycle N -> PUSH in N+1 -> out_valid in N+2 (FIFO empty,
//   not full). ACC does not resume until the push completes, so column back-pressure is via sum_ready.
//  FIFO order is strict first-in first-out; out_data changes only on pop or push-into-empty.
//  done pulses in the DONE cycle. FIFO may still hold results; busy drops in the next cycle.
//  Accumulator overflow wraps. Size ACC_BITLEN, tiles and cfg_shift so that overflow cannot occur.
// TESTING
//  simd=1, tiles=3, shift=0, partials 100,200,300, out_ready=1 -> out_data 600, one out_valid, done.
//  simd=1, tiles=2, shift=4, partials 32'h0008_0000 x2 -> 16'hFFFF (saturated); shift=16 -> 16'h0010.
//  simd=0, tiles=2, shift=2, partials {16'h0100,16'h0010} x2 -> lanes 0x200>>2=0x80, 0x20>>2=0x08 -> 16'h8008.
//  num_out=6, tiles=1, out_ready=0 -> 4 results queued, sum_ready low; release out_ready -> all 6 in order.
//  cfg_num_out=0 -> done 2 cycles after start, no out_valid; start while busy -> ignored.
//  rst_n low mid-job with FIFO holding 2 -> out_valid 0, busy 0 immediately; next job runs cleanly.

Source files
------------

// File: rtl/vmx_col_accum.sv
// Drain stage under one vmx PE column: accumulates tiled partial sums per output element,
// requantizes with unsigned saturation and queues results in a small valid/ready FIFO.
module vmx_col_accum #(
  parameter int SUM_BITLEN = 32,
  parameter int ACC_BITLEN = 40,
  parameter int OUT_BITLEN = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  cfg_simd_i,
  input  logic [7:0]            cfg_tiles_i,
  input  logic [7:0]            cfg_num_out_i,
  input  logic [4:0]            cfg_shift_i,
  input  logic [SUM_BITLEN-1:0] sum_in_i,
  input  logic                  sum_valid_i,
  output logic                  sum_ready_o,
  output logic [OUT_BITLEN-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LANE_BITLEN = 24;
  localparam int HALF        = SUM_BITLEN / 2;
  localparam int LANE_OUT    = OUT_BITLEN / 2;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACC, PUSH, DONE} state_t;

  function automatic logic [OUT_BITLEN-1:0] sat_wide(input logic [ACC_BITLEN-1:0] a,
                                                     input logic [4:0] sh);
    logic [ACC_BITLEN-1:0] r;
    r = a >> sh;
    return (|r[ACC_BITLEN-1:OUT_BITLEN]) ? '1 : r[OUT_BITLEN-1:0];
  endfunction

  function automatic logic [LANE_OUT-1:0] sat_lane(input logic [LANE_BITLEN-1:0] a,
                                                   input logic [4:0] sh);
    logic [LANE_BITLEN-1:0] r;
    r = a >> sh;
    return (|r[LANE_BITLEN-1:LANE_OUT]) ? '1 : r[LANE_OUT-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic                   simd_q, simd_d;
  logic [7:0]             tiles_q, tiles_d;
  logic [7:0]             num_out_q, num_out_d;
  logic [4:0]             shift_q, shift_d;
  logic [7:0]             tile_cnt_q, tile_cnt_d;
  logic [7:0]             out_cnt_q, out_cnt_d;
  logic [ACC_BITLEN-1:0]  acc_q, acc_d;
  logic [LANE_BITLEN-1:0] lane0_q, lane0_d, lane1_q, lane1_d;

  logic [OUT_BITLEN-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   fifo_full, push, pop, first;
  logic [OUT_BITLEN-1:0]  push_data;

  assign fifo_full   = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign out_valid_o = (cnt_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign busy_o      = (state_q != IDLE);
  assign first       = (tile_cnt_q == 8'd0);
  assign push_data   = simd_q ? sat_wide(acc_q, shift_q)
                              : {sat_lane(lane1_q, shift_q), sat_lane(lane0_q, shift_q)};

  always_comb begin
    state_d     = state_q;
    simd_d      = simd_q;
    tiles_d     = tiles_q;
    num_out_d   = num_out_q;
    shift_d     = shift_q;
    tile_cnt_d  = tile_cnt_q;
    out_cnt_d   = out_cnt_q;
    acc_d       = acc_q;
    lane0_d     = lane0_q;
    lane1_d     = lane1_q;
    push        = 1'b0;
    sum_ready_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          simd_d     = cfg_simd_i;
          tiles_d    = (cfg_tiles_i == 8'd0) ? 8'd1 : cfg_tiles_i;
          num_out_d  = cfg_num_out_i;
          shift_d    = cfg_shift_i;
          tile_cnt_d = 8'd0;
          out_cnt_d  = 8'd0;
          state_d    = (cfg_num_out_i == 8'd0) ? DONE : ACC;
        end
      end
      ACC: begin
        sum_ready_o = 1'b1;
        if (sum_valid_i) begin
          // Both lane views are kept current; simd_q only selects which one is requantized.
          acc_d   = (first ? '0 : acc_q) + ACC_BITLEN'(sum_in_i);
          lane0_d = (first ? '0 : lane0_q) + LANE_BITLEN'(sum_in_i[HALF-1:0]);
          lane1_d = (first ? '0 : lane1_q) + LANE_BITLEN'(sum_in_i[SUM_BITLEN-1:HALF]);
          if (tile_cnt_q == tiles_q - 8'd1) begin
            tile_cnt_d = 8'd0;
            state_d    = PUSH;
          end else begin
            tile_cnt_d = tile_cnt_q + 8'd1;
          end
        end
      end
      PUSH: begin
        if (!fifo_full) begin
          push      = 1'b1;
          out_cnt_d = out_cnt_q + 8'd1;
          state_d   = (out_cnt_q == num_out_q - 8'd1) ? DONE : ACC;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      simd_q     <= 1'b0;
      tiles_q    <= 8'd0;
      num_out_q  <= 8'd0;
      shift_q    <= 5'd0;
      tile_cnt_q <= 8'd0;
      out_cnt_q  <= 8'd0;
      acc_q      <= '0;
      lane0_q    <= '0;
      lane1_q    <= '0;
    end else begin
      state_q    <= state_d;
      simd_q     <= simd_d;
      tiles_q    <= tiles_d;
      num_out_q  <= num_out_d;
      shift_q    <= shift_d;
      tile_cnt_q <= tile_cnt_d;
      out_cnt_q  <= out_cnt_d;
      acc_q      <= acc_d;
      lane0_q    <= lane0_d;
      lane1_q    <= lane1_d;
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never makes room for a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_vmx_col_accum.sv
// Directed bench for vmx_col_accum with a scoreboard queue of expected FIFO results.
module tb_vmx_col_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        cfg_simd_i;
  logic [7:0]  cfg_tiles_i;
  logic [7:0]  cfg_num_out_i;
  logic [4:0]  cfg_shift_i;
  logic [31:0] sum_in_i;
  logic        sum_valid_i;
  logic        sum_ready_o;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;

  int          errors = 0;
  int          checks = 0;
  int          pops   = 0;
  int          pops_base;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  vmx_col_accum dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .cfg_simd_i   (cfg_simd_i),
    .cfg_tiles_i  (cfg_tiles_i),
    .cfg_num_out_i(cfg_num_out_i),
    .cfg_shift_i  (cfg_shift_i),
    .sum_in_i     (sum_in_i),
    .sum_valid_i  (sum_valid_i),
    .sum_ready_o  (sum_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every handshake seen on the output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed=%0h expected=none", out_data_o);
        end
      end else begin
        mon_exp = exp_q.pop_front();
        assert (out_data_o === mon_exp) else begin
          errors++;
          $error("FAIL out_data: observed=%0h expected=%0h", out_data_o, mon_exp);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic simd, input logic [7:0] tiles, input logic [7:0] num,
                           input logic [4:0] shift);
    cfg_simd_i    = simd;
    cfg_tiles_i   = tiles;
    cfg_num_out_i = num;
    cfg_shift_i   = shift;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    bit ok;
    ok          = 1'b0;
    sum_in_i    = v;
    sum_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sum_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    sum_valid_i = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid_o) break;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; cfg_simd_i = 1'b0; cfg_tiles_i = 8'd0;
    cfg_num_out_i = 8'd0; cfg_shift_i = 5'd0; sum_in_i = 32'd0; sum_valid_i = 1'b0;
    out_ready_i = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sum_ready", 32'(sum_ready_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // simd=1, tiles=3: 100+200+300, with exact push latency
    out_ready_i = 1'b1;
    pops_base   = pops;
    exp_q.push_back(16'd600);
    start_job(1'b1, 8'd3, 8'd1, 5'd0);
    check("busy_in_job", 32'(busy_o), 32'd1);
    send(32'd100);
    send(32'd200);
    send(32'd300);
    @(negedge clk);
    check("lat_push_cycle_valid", 32'(out_valid_o), 32'd0);
    tick();
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid_o), 32'd1);
    check("lat_done", 32'(done_o), 32'd1);
    tick();
    @(negedge clk);
    check("busy_after_done", 32'(busy_o), 32'd0);
    check("t1_single_out", 32'(pops - pops_base), 32'd1);
    tick();

    // 16-bit saturation and in-range shift
    exp_q.push_back(16'hFFFF);
    start_job(1'b1, 8'd2, 8'd1, 5'd4);
    send(32'h0008_0000);
    send(32'h0008_0000);
    wait_done("sat_done");
    tick();
    exp_q.push_back(16'h0010);
    start_job(1'b1, 8'd2, 8'd1, 5'd16);
    send(32'h0008_0000);
    send(32'h0008_0000);
    wait_done("shift16_done");
    wait_empty("t2_drained");
    tick();

    // dual 8-bit lanes: plain, saturating lane, no cross-lane carry; tiles=0 acts as 1
    exp_q.push_back(16'h8008);
    exp_q.push_back(16'hFF08);
    exp_q.push_back(16'h02FF);
    exp_q.push_back(16'h0C05);
    start_job(1'b0, 8'd2, 8'd3, 5'd2);
    send(32'h0100_0010);
    send(32'h0100_0010);
    send(32'h3FFF_0010);
    send(32'h3FFF_0010);
    send(32'h0004_FFFF);
    send(32'h0004_FFFF);
    wait_done("simd0_done");
    tick();
    start_job(1'b0, 8'd0, 8'd1, 5'd0);
    send(32'h000C_0005);
    wait_done("tiles0_done");
    wait_empty("t3_drained");
    tick();

    // back-pressure: 6 results with consumer stalled
    out_ready_i = 1'b0;
    pops_base   = pops;
    start_job(1'b1, 8'd1, 8'd6, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(16'(11 * k));
      send(32'(11 * k));
    end
    exp_q.push_back(16'd66);
    sum_in_i    = 32'd66;
    sum_valid_i = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_sum_ready", 32'(sum_ready_o), 32'd0);
    check("bp_out_valid", 32'(out_valid_o), 32'd1);
    check("bp_head_stable", 32'(out_data_o), 32'd11);
    tick();
    out_ready_i = 1'b1;
    send(32'd66);
    wait_done("bp_done");
    wait_empty("bp_drained");
    check("bp_count", 32'(pops - pops_base), 32'd6);
    tick();

    // empty job, then start while busy is ignored
    pops_base = pops;
    start_job(1'b1, 8'd1, 8'd0, 5'd0);
    wait_done("empty_done");
    check("empty_no_valid", 32'(out_valid_o), 32'd0);
    tick();
    @(negedge clk);
    check("empty_idle", 32'(busy_o), 32'd0);
    check("empty_no_out", 32'(pops - pops_base), 32'd0);
    tick();
    exp_q.push_back(16'h1234);
    start_job(1'b1, 8'd1, 8'd1, 5'd0);
    start_job(1'b0, 8'd5, 8'd3, 5'd3);
    send(32'h0000_1234);
    wait_done("restart_ignored_done");
    wait_empty("restart_drained");
    tick();

    // asynchronous reset mid-job with two results queued
    out_ready_i = 1'b0;
    start_job(1'b1, 8'd1, 8'd4, 5'd0);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd6);
    send(32'd5);
    send(32'd6);
    tick();
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid_o), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    out_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(16'd77);
    start_job(1'b1, 8'd1, 8'd1, 5'd0);
    send(32'd77);
    wait_done("post_rst_done");
    wait_empty("post_rst_drained");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
